majority_scan_ctrl: RTL and testbench
=====================================

// Module: majority_scan_ctrl
// PURPOSE
//  Scheduler that time-shares one external pair/triple (2-of-3 majority) detector across N_CH 3-bit
//  input channels. On each prescaler tick or start request it snapshots all channels and drives
//  each channel into the detector in turn. It collects the per-channel decisions and publishes the
//  result vector, a hit count on a 7-seg digit and a saturating running total.
//  Sits between the pin-level inputs (switches/uio) and the shared detector + 7-seg output.
// PARAMETERS
//  MAX_COUNT  10_000_000  prescaler period in clk cycles (tick every MAX_COUNT cycles); legal >= 2
//  N_CH       4           number of 3-bit channels scanned; legal 1..9
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  ena          in   1        design enable; low freezes the prescaler
//  start        in   1        single-cycle scan request (already synchronised upstream)
//  ch_in        in   3*N_CH   channel k = ch_in[3k+2:3k]
//  det_in       out  3        registered operand to the shared detector
//  det_out      in   1        detector decision for det_in (combinational, settles within 1 cycle)
//  result       out  N_CH     bit k = detector decision for channel k, last completed scan
//  valid        out  1        one-cycle pulse: result/seg_out/total_hits just updated
//  busy         out  1        high while a scan is in progress (state != IDLE)
//  overrun      out  1        sticky: a tick or start arrived while busy
//  seg_out      out  7        {g,f,e,d,c,b,a} active-high digit = popcount(result)
//  total_hits   out  8        saturating sum of popcount over all completed scans
// BEHAVIOUR
//  Reset (async, rst_n=0): prescaler=0, state=IDLE, idx=0, det_in=0, result=0, valid=0, busy=0,
//   overrun=0, total_hits=0, seg_out=7'h3F (digit 0). Reset mid-scan aborts; no valid follows.
//  Prescaler: counts 0..MAX_COUNT-1 while ena=1, holds while ena=0; tick=1 the cycle cnt==MAX_COUNT-1
//   (then wraps to 0). Runs regardless of FSM state.
//  FSM states: IDLE, DRIVE, SAMPLE, DONE. trig = tick | start.
//   IDLE:   trig -> snap<=ch_in, idx<=0, go DRIVE. tick and start together = one scan.
//   DRIVE:  det_in<=snap[idx]; go SAMPLE.
//   SAMPLE: shadow[idx]<=det_out; idx==N_CH-1 -> go DONE, else idx<=idx+1, go DRIVE.
//   DONE:   result<=shadow, seg_out<=enc(popcount(shadow)),
//           total_hits<=min(255, total_hits+popcount); go IDLE.
//  valid registered, high exactly the cycle after DONE. busy = state in {DRIVE,SAMPLE,DONE}.
//  Timing: trig seen in cycle 0 -> DRIVE ch0 in cycle 1 -> SAMPLE ch(N_CH-1) in cycle 2*N_CH ->
//   DONE in cycle 2*N_CH+1 -> valid in cycle 2*N_CH+2 (cycle 10 for N_CH=4). det_in holds last value.
//  ch_in changes after the snapshot edge do not affect the scan in progress.
//  trig while busy (including in DONE): dropped; overrun<=1, held until reset.
//   No queuing: next scan needs the next trig in IDLE.
//  ena=0 blocks tick only. start is still honoured; an in-progress scan completes normally.
//  seg enc: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//  total_hits saturates at 8'hFF and never wraps.
// TESTING (MAX_COUNT=16, N_CH=4, det_out driven by a behavioural majority model)
//  1 Reset: rst_n=0 -> all outputs at reset values, seg_out=3F; release -> first tick at cycle 15, valid at cycle 25.
//  2 ch_in=12'b111_011_001_000, start pulse -> det_in 000,001,011,111 in cycles 1,3,5,7;
//    result=4'b1100, valid in cycle 10, seg_out=5B, total_hits=2.
//  3 Flip ch_in to all-1s at cycle 4 of the scan in 2 -> result still 4'b1100; next scan -> 4'b1111, seg_out=66.
//  4 start coincident with tick -> exactly one valid; start at cycle 5 of a scan -> dropped, overrun=1 until reset.
//  5 MAX_COUNT=4 -> ticks land mid-scan, overrun=1; scans still complete in order.
//    ena=0 for 100 cycles -> no tick-driven valid.
//  6 ch_in all-1s, 64 scans -> total_hits 4,8,..,252 then 255 and held.
//    rst_n=0 at scan cycle 5 -> immediate reset values, no valid after release.

Source files
------------

// File: rtl/majority_scan_ctrl.sv
// Time-shares one external 2-of-3 majority detector across N_CH 3-bit channels.
// Each scan snapshots all channels, feeds them to the detector and publishes result, 7-seg digit and running total.
module majority_scan_ctrl #(
  parameter int MAX_COUNT = 10_000_000,
  parameter int N_CH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [3*N_CH-1:0] ch_in,
  output logic [2:0]        det_in,
  input  logic              det_out,
  output logic [N_CH-1:0]   result,
  output logic              valid,
  output logic              busy,
  output logic              overrun,
  output logic [6:0]        seg_out,
  output logic [7:0]        total_hits
);

  localparam int CW = $clog2(MAX_COUNT);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            trig;
  logic [IW-1:0]   idx;
  logic [2:0]      snap [N_CH];
  logic [N_CH-1:0] shadow;
  logic [3:0]      hits;
  logic [8:0]      total_sum;

  function automatic logic [3:0] popcount(input logic [N_CH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < N_CH; k++) c = c + {3'b000, v[k]};
    return c;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Prescaler runs independently of the scan FSM; ena only freezes it.
  // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (ena) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = ena && (cnt == CNT_LAST);
  assign trig = tick || start;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = DRIVE;
      DRIVE:   state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == IDX_LAST) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the snapshot array has no reset; it is always loaded at scan start before being read.
  always_ff @(posedge clk) begin
    if (state == IDLE && trig)
      for (int k = 0; k < N_CH; k++) snap[k] <= ch_in[3*k +: 3];
  end

  assign hits      = popcount(shadow);
  assign total_sum = {1'b0, total_hits} + {5'b00000, hits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      det_in     <= '0;
      shadow     <= '0;
      result     <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      seg_out    <= 7'h3F;
      total_hits <= '0;
    end else begin
      valid <= (state == DONE);
      // A trigger is never queued; it only leaves a sticky mark.
      if (trig && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE:   if (trig) idx <= '0;
        DRIVE:  det_in <= snap[idx];
        SAMPLE: begin
          shadow[idx] <= det_out;
          if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
        DONE: begin
          result     <= shadow;
          seg_out    <= seg_enc(hits);
          total_hits <= total_sum[8] ? 8'hFF : total_sum[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_majority_scan_ctrl.sv
// Directed bench for majority_scan_ctrl: one DUT at MAX_COUNT=16 and one at MAX_COUNT=4, both N_CH=4.
// Each detector is a behavioural 2-of-3 majority; cycle k is the interval after the k-th rising edge.
`timescale 1ns/1ps
module tb_majority_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, ena, ena4, start;
  logic [11:0] ch_in;

  logic [2:0]  det_in, det_in4;
  logic        det_out, det_out4;
  logic [3:0]  result, result4;
  logic        valid, valid4, busy, busy4, overrun, overrun4;
  logic [6:0]  seg_out, seg_out4;
  logic [7:0]  total_hits, total_hits4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign det_out  = (det_in[0]  & det_in[1])  | (det_in[0]  & det_in[2])  | (det_in[1]  & det_in[2]);
  assign det_out4 = (det_in4[0] & det_in4[1]) | (det_in4[0] & det_in4[2]) | (det_in4[1] & det_in4[2]);

  majority_scan_ctrl #(.MAX_COUNT(16), .N_CH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .ch_in(ch_in),
    .det_in(det_in), .det_out(det_out), .result(result), .valid(valid), .busy(busy),
    .overrun(overrun), .seg_out(seg_out), .total_hits(total_hits)
  );

  majority_scan_ctrl #(.MAX_COUNT(4), .N_CH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .start(1'b0), .ch_in(ch_in),
    .det_in(det_in4), .det_out(det_out4), .result(result4), .valid(valid4), .busy(busy4),
    .overrun(overrun4), .seg_out(seg_out4), .total_hits(total_hits4)
  );

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench in cycle 1 of the scan (edge 0 sampled start).
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    first = -1;
    ena = 1'b1; ena4 = 1'b1; start = 1'b0; ch_in = '0; rst_n = 1'b0;
    step();
    total++;
    if ({det_in, result, valid, busy, overrun, seg_out, total_hits} !==
        {3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 7'h3F, 8'h00}) begin
      bad++;
      $display("FAIL reset_values: got det=%b res=%b v=%b b=%b ovr=%b seg=%h tot=%h expected all zero, seg=3f",
               det_in, result, valid, busy, overrun, seg_out, total_hits);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 40 && first < 0; c++) begin
      step();
      if (valid === 1'b1) first = c;
    end
    ena = 1'b0;
    total++;
    if (first != 25) begin
      bad++;
      $display("FAIL first_tick_valid: got cycle %0d expected cycle 25", first);
    end
    total++;
    if ({result, seg_out, total_hits} !== {4'b0000, 7'h3F, 8'h00}) begin
      bad++;
      $display("FAIL tick_scan_zero: got res=%b seg=%h tot=%h expected 0000/3f/00", result, seg_out, total_hits);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_det [4];
    exp_det = '{3'b000, 3'b001, 3'b011, 3'b111};
    ch_in = 12'b111_011_001_000;
    pulse_start();
    for (int c = 1; c <= 11; c++) begin
      // DRIVE in cycles 1,3,5,7 registers det_in, visible in cycles 2,4,6,8.
      if (c % 2 == 0 && c <= 8) begin
        total++;
        if (det_in !== exp_det[c/2-1]) begin
          bad++;
          $display("FAIL det_in_c%0d: got %b expected %b", c, det_in, exp_det[c/2-1]);
        end
      end
      total++;
      if (busy !== (c <= 9)) begin
        bad++;
        $display("FAIL busy_c%0d: got %b expected %b", c, busy, (c <= 9));
      end
      total++;
      if (valid !== (c == 10)) begin
        bad++;
        $display("FAIL valid_c%0d: got %b expected %b", c, valid, (c == 10));
      end
      if (c == 10) begin
        total++;
        if ({result, seg_out, total_hits} !== {4'b1100, 7'h5B, 8'd2}) begin
          bad++;
          $display("FAIL basic_result: got res=%b seg=%h tot=%0d expected 1100/5b/2", result, seg_out, total_hits);
        end
      end
      step();
    end
    total++;
    if (det_in !== 3'b111) begin
      bad++;
      $display("FAIL det_in_hold: got %b expected 111", det_in);
    end
  endtask

  task automatic test_snapshot();
    ch_in = 12'b111_011_001_000;
    pulse_start();
    repeat (3) step();
    ch_in = 12'hFFF;
    repeat (6) step();
    total++;
    if ({valid, result, total_hits} !== {1'b1, 4'b1100, 8'd4}) begin
      bad++;
      $display("FAIL snapshot_hold: got v=%b res=%b tot=%0d expected 1/1100/4", valid, result, total_hits);
    end
    repeat (2) step();
    pulse_start();
    repeat (9) step();
    total++;
    if ({valid, result, seg_out, total_hits} !== {1'b1, 4'b1111, 7'h66, 8'd8}) begin
      bad++;
      $display("FAIL snapshot_next: got v=%b res=%b seg=%h tot=%0d expected 1/1111/66/8",
               valid, result, seg_out, total_hits);
    end
    repeat (2) step();
  endtask

  task automatic test_overlap();
    int vcnt;
    ch_in = '0;
    ena = 1'b1;
    reset_dut();
    repeat (15) step();
    start = 1'b1;
    step();
    start = 1'b0;
    vcnt = 0;
    for (int c = 17; c <= 30; c++) begin
      step();
      if (valid === 1'b1) vcnt++;
    end
    ena = 1'b0;
    total++;
    if (vcnt != 1) begin
      bad++;
      $display("FAIL tick_start_one_scan: got %0d valids expected 1", vcnt);
    end
    total++;
    if ({overrun, busy} !== 2'b00) begin
      bad++;
      $display("FAIL tick_start_no_overrun: got ovr=%b busy=%b expected 0/0", overrun, busy);
    end
    ch_in = 12'hFFF;
    pulse_start();
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    vcnt = 0;
    for (int c = 7; c <= 20; c++) begin
      step();
      if (valid === 1'b1) vcnt++;
    end
    total++;
    if ({vcnt == 1, result, busy} !== {1'b1, 4'b1111, 1'b0}) begin
      bad++;
      $display("FAIL dropped_start: got valids=%0d res=%b busy=%b expected 1/1111/0", vcnt, result, busy);
    end
    pulse_start();
    repeat (11) step();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_fast_prescaler();
    int vcnt;
    ch_in = 12'b111_011_001_000;
    repeat (24) step();
    vcnt = 0;
    for (int c = 0; c < 48; c++) begin
      step();
      if (valid4 === 1'b1) begin
        vcnt++;
        total++;
        if (result4 !== 4'b1100) begin
          bad++;
          $display("FAIL fast_result: got %b expected 1100", result4);
        end
      end
    end
    total++;
    if (vcnt != 4) begin
      bad++;
      $display("FAIL fast_scan_rate: got %0d valids in 48 cycles expected 4", vcnt);
    end
    total++;
    if (overrun4 !== 1'b1) begin
      bad++;
      $display("FAIL fast_overrun: got %b expected 1", overrun4);
    end
    ena4 = 1'b0;
    repeat (12) step();
    vcnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (valid4 === 1'b1) vcnt++;
    end
    total++;
    if (vcnt != 0) begin
      bad++;
      $display("FAIL ena_low_no_tick: got %0d valids expected 0", vcnt);
    end
  endtask

  task automatic test_saturate();
    int exp_tot;
    ch_in = 12'hFFF;
    reset_dut();
    for (int k = 1; k <= 66; k++) begin
      exp_tot = (4 * k > 255) ? 255 : 4 * k;
      pulse_start();
      repeat (9) step();
      total++;
      if ({valid, total_hits} !== {1'b1, 8'(exp_tot)}) begin
        bad++;
        $display("FAIL total_scan%0d: got v=%b tot=%0d expected 1/%0d", k, valid, total_hits, exp_tot);
      end
      repeat (2) step();
    end
  endtask

  task automatic test_reset_mid_scan();
    int vcnt;
    pulse_start();
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({det_in, result, valid, busy, overrun, seg_out, total_hits} !==
        {3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 7'h3F, 8'h00}) begin
      bad++;
      $display("FAIL midscan_reset: got det=%b res=%b v=%b b=%b ovr=%b seg=%h tot=%h expected all zero, seg=3f",
               det_in, result, valid, busy, overrun, seg_out, total_hits);
    end
    @(negedge clk);
    step();
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (valid === 1'b1) vcnt++;
    end
    total++;
    if ({vcnt == 0, busy} !== 2'b10) begin
      bad++;
      $display("FAIL midscan_no_valid: got valids=%0d busy=%b expected 0/0", vcnt, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; ena4 = 1'b0; start = 1'b0; ch_in = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_snapshot();
    test_overlap();
    test_fast_prescaler();
    test_saturate();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
